// File: rtl/tff_count_ctrl.sv
// Sequencing controller for a bank of T flip-flops run as a programmable modulo counter.
// Produces the per-cycle toggle vector, holds the bank state, and sequences start/stop/one-shot/wrap.
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             dir_r;
    logic             os_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] start_val_r;
    logic [WIDTH-1:0] start_val_in;
    logic [WIDTH-1:0] count_tvec;
    logic             load_cfg;

    assign term_val     = dir_r ? mod_r : '0;
    assign start_val_r  = dir_r ? '0 : mod_r;
    assign start_val_in = up_dn ? '0 : mod_val;
    assign tc           = (state == RUN) && (q == term_val);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    // Ripple-style toggle terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        count_tvec = '0;
        carry      = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            count_tvec[i] = carry;
            carry         = carry & (dir_r ? q[i] : ~q[i]);
        end
    end

    always_comb begin
        next_state = state;
        t_vec      = '0;
        load_cfg   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RUN;
                    t_vec      = q ^ start_val_in;
                    load_cfg   = 1'b1;
                end else if (stop && state == DONE) begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (q == term_val) begin
                    if (os_r) begin
                        next_state = DONE;
                    end else begin
                        t_vec = q ^ start_val_r;
                    end
                end else begin
                    t_vec = count_tvec;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The bank only ever changes through t_vec, on the same falling edge as the T-flop cells.
    always_ff @(negedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            dir_r <= 1'b0;
            os_r  <= 1'b0;
            mod_r <= '0;
        end else begin
            state <= next_state;
            q     <= q ^ t_vec;
            if (load_cfg) begin
                dir_r <= up_dn;
                os_r  <= oneshot;
                mod_r <= mod_val;
            end
        end
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomized and directed scoreboard bench for tff_count_ctrl (WIDTH=4) against a behavioural counter model.
module tb_tff_count_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             up_dn;
    logic             oneshot;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             done;

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .up_dn   (up_dn),
        .oneshot (oneshot),
        .mod_val (mod_val),
        .t_vec   (t_vec),
        .q       (q),
        .busy    (busy),
        .tc      (tc),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             chk_comb;
        logic [WIDTH-1:0] exp_tvec;
        logic             exp_tc;
        logic [WIDTH-1:0] exp_q;
        logic             exp_busy;
        logic             exp_done;
    } exp_t;

    exp_t exp_q_fifo[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished; count is plain arithmetic.
    int               m_mode  = 0;
    logic [WIDTH-1:0] m_count = '0;
    logic             m_up    = 1'b0;
    logic             m_os    = 1'b0;
    logic [WIDTH-1:0] m_mod   = '0;
    logic             m_known = 1'b0;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic ud, input logic os,
                                 input logic [WIDTH-1:0] mv, input logic r);
        exp_t             e;
        logic [WIDTH-1:0] term;
        logic [WIDTH-1:0] nq;
        int               nmode;
        @(posedge clk);
        #1;
        start   = s;
        stop    = sp;
        up_dn   = ud;
        oneshot = os;
        mod_val = mv;
        rst     = r;

        term     = m_up ? m_mod : '0;
        e.exp_tc = (m_mode == 1) && (m_count == term);
        nq       = m_count;
        nmode    = m_mode;
        if (m_mode != 1) begin
            if (s) begin
                m_up  = ud;
                m_os  = os;
                m_mod = mv;
                nq    = ud ? '0 : mv;
                nmode = 1;
            end else if (sp && m_mode == 2) begin
                nmode = 0;
            end
        end else begin
            if (sp) begin
                nmode = 0;
            end else if (m_count == term) begin
                if (m_os) nmode = 2;
                else nq = m_up ? '0 : m_mod;
            end else begin
                nq = m_up ? m_count + 1'b1 : m_count - 1'b1;
            end
        end
        e.chk_comb = m_known;
        e.exp_tvec = m_count ^ nq;
        if (r) begin
            nq      = '0;
            nmode   = 0;
            m_up    = 1'b0;
            m_os    = 1'b0;
            m_mod   = '0;
            m_known = 1'b1;
        end
        m_count    = nq;
        m_mode     = nmode;
        e.exp_q    = nq;
        e.exp_busy = (nmode == 1);
        e.exp_done = (nmode == 2);
        exp_q_fifo.push_back(e);
    endtask

    // Monitor: combinational outputs before the falling edge, registered ones after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q_fifo.size() > 0) begin
                e = exp_q_fifo.pop_front();
                if (e.chk_comb) begin
                    checkOutput("t_vec", t_vec, e.exp_tvec);
                    checkOutput("tc", {{(WIDTH-1){1'b0}}, tc}, {{(WIDTH-1){1'b0}}, e.exp_tc});
                end
                @(negedge clk);
                #1;
                checkOutput("q", q, e.exp_q);
                checkOutput("busy", {{(WIDTH-1){1'b0}}, busy}, {{(WIDTH-1){1'b0}}, e.exp_busy});
                checkOutput("done", {{(WIDTH-1){1'b0}}, done}, {{(WIDTH-1){1'b0}}, e.exp_done});
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int waited;
        start = 0; stop = 0; up_dn = 0; oneshot = 0; mod_val = '0; rst = 1;
        applyStimulus(0, 0, 0, 0, 4'd0, 1);
        applyStimulus(0, 0, 0, 0, 4'd0, 1);
        idleCycles(2);

        // Up wrap, modulus 5, then reset mid-run.
        applyStimulus(1, 0, 1, 0, 4'd5, 0);
        idleCycles(9);
        applyStimulus(0, 0, 0, 0, 4'd0, 1);
        applyStimulus(0, 0, 0, 0, 4'd0, 1);
        idleCycles(1);

        // Down one-shot from 3, restart from DONE, then leave DONE with stop.
        applyStimulus(1, 0, 0, 1, 4'd3, 0);
        idleCycles(6);
        applyStimulus(1, 0, 0, 1, 4'd3, 0);
        idleCycles(5);
        applyStimulus(0, 1, 0, 0, 4'd0, 0);
        idleCycles(1);

        // Stop at q=6 with a concurrent start that must be ignored.
        applyStimulus(1, 0, 1, 0, 4'd9, 0);
        idleCycles(6);
        applyStimulus(1, 1, 1, 0, 4'd2, 0);
        idleCycles(3);

        // Full-range wrap through all-ones.
        applyStimulus(1, 0, 1, 0, 4'd15, 0);
        idleCycles(18);
        applyStimulus(0, 1, 0, 0, 4'd0, 0);

        // Modulus 0 one-shot reaches DONE one edge after start.
        applyStimulus(1, 0, 1, 1, 4'd0, 0);
        idleCycles(3);
        applyStimulus(1, 0, 0, 0, 4'd0, 0);
        idleCycles(3);
        applyStimulus(0, 1, 0, 0, 4'd0, 0);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 99) == 0));
        end

        idleCycles(2);
        waited = 0;
        while (exp_q_fifo.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        if (exp_q_fifo.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q_fifo.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of T flip-flops configured as a programmable modulo counter. Each cycle it computes the toggle vector `t_vec` for a WIDTH-bit T-flop bank, holds the bank state internally, and runs a small FSM for start, stop, one-shot and free-running operation. It sits between control logic that issues start/stop commands and datapath consumers of the count and terminal-count strobe.

## Interface
- `WIDTH`, default 4: number of T flip-flops (count bits), legal range 2..16.

- `clk`  input  1  clock; all state changes on the falling edge, matching the T-flop cells it drives
- `rst`  input  1  synchronous, active-high reset; sampled on the falling edge of `clk`
- `start`  input  1  one-cycle command: latch config and begin counting
- `stop`  input  1  one-cycle command: abort counting, return to IDLE
- `up_dn`  input  1  direction, sampled at start: 1 = up, 0 = down
- `oneshot`  input  1  mode, sampled at start: 1 = stop at terminal, 0 = wrap
- `mod_val`  input  WIDTH  terminal value, sampled at start
- `t_vec`  output  WIDTH  toggle vector applied at the next edge (combinational from state)
- `q`  output  WIDTH  current bank state (count)
- `busy`  output  1  high in RUN
- `tc`  output  1  terminal count: high while in RUN and `q` equals the terminal value
- `done`  output  1  high in DONE

## Operation
- Bank update every falling edge: `q <= q ^ t_vec`. All `q` changes go through `t_vec`; there is no other write path.
- Latched at start: `dir_r` from `up_dn`, `os_r` from `oneshot`, `mod_r` from `mod_val`.
- Start value: `start_val` is 0 when counting up and `mod_r` when counting down.
- Terminal value: `term_val` is `mod_r` when counting up and 0 when counting down.
- FSM states:
  - IDLE: `t_vec` = 0 and `q` holds. `start` moves to RUN and sets `t_vec = q ^ start_val(up_dn, mod_val)`, using the unlatched inputs in that cycle. `stop` is ignored.
  - RUN, `q != term_val`:
    - Up: `t_vec[0]=1`, `t_vec[i] = &q[i-1:0]`.
    - Down: `t_vec[0]=1`, `t_vec[i] = &(~q[i-1:0])`.
  - RUN, `q == term_val`: `tc=1`.
    - If `os_r=0`: `t_vec = q ^ start_val` (wrap), stay in RUN.
    - If `os_r=1`: `t_vec = 0`, go to DONE.
  - DONE: `t_vec = 0`, `q` holds the terminal value, `done=1`. `start` re-enters RUN exactly as from IDLE. `stop` moves to IDLE with `q` held.
- Priorities:
  - In RUN, `stop` has priority over counting and terminal handling: `t_vec = 0`, go to IDLE, `q` frozen.
  - `start` is ignored in RUN.
  - `rst` overrides everything.
- `mod_val = 0`: the count is stuck at 0 and `tc` is high every RUN cycle. In one-shot mode the FSM reaches DONE one edge after entering RUN.
- `mod_val` values above the WIDTH range cannot occur. A count that equals all-ones wraps through its natural T-flop overflow only if `mod_r` is all-ones; this is consistent with the rules above.

## Timing
- Reset: on the first falling edge with `rst=1`, outputs become `q=0`, FSM=IDLE, `busy=0`, `done=0`, `tc=0`, `t_vec=0`, and all latched config is 0. Reset takes effect mid-run with no further toggles.
- Start latency: `start` is sampled at edge N. At edge N `q` becomes `start_val` and `busy=1`. The first increment or decrement lands at edge N+1.
- Free-running up with modulus M: `q` sequence is 0,1,…,M,0,… with a period of M+1 edges. `tc` is high during the cycle where `q=M`.
- One-shot: at the edge after `tc`, `q` holds and `done=1`. `busy` falls at that same edge.
- `stop` sampled at edge N: `busy=0` after edge N and `q` keeps its edge-(N−1) value.
- Outputs `q`, `busy`, `done` are registered. `t_vec` and `tc` are combinational from registered state only, with no input-to-output path except the `start` cycle in IDLE/DONE and the `stop` cycle in RUN.

## Test plan
- Reset: assert `rst` for 2 cycles during RUN with `q=3` → `q=0`, `busy=0`, `done=0`, `tc=0`, `t_vec=0`.
- Up wrap, WIDTH=4, `mod_val=5`, `oneshot=0`: start → `q` 0,1,2,3,4,5,0,1; `tc` high only at `q=5`; `t_vec=4'b0101` in the `q=5` cycle.
- Down one-shot, `mod_val=3`: start → `q` 3,2,1,0 then holds 0; `done=1`, `busy=0`; a second `start` restarts at 3.
- Stop mid-run: up, `mod_val=9`, assert `stop` when `q=6` → `q` stays 6, state IDLE; a concurrent `start` in that cycle is ignored.
- Edge cases, WIDTH=4:
  - `mod_val=15` up: 15→0 wrap via `t_vec=4'b1111`.
  - `mod_val=0` one-shot: DONE one edge after start, `q=0`.
